uart_rx_frame: RTL

//  UART receive framer; consumes the oversampling clock (rxClk) from the baud rate generator.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_rx_frame.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: receiver state type and oversampling-ratio constants shared by the UART RX blocks.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
    localparam logic [4:0] OSM_13 = 5'd13;
    localparam logic [4:0] OSM_16 = 5'd16;
    function automatic logic [4:0] osm_n(input logic osmSel);
        return osmSel ? OSM_13 : OSM_16;
    endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: rxd synchroniser (idles high) and single-clk tick on each rising edge of rxClk.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstN,
    input  logic rxd,
    input  logic rxClk,
    output logic rxdS,
    output logic tick
);
    logic [SYNC_STAGES-1:0] syncQ;
    logic                   rxClkQ;
    // rxClkQ resets high so leaving reset never fabricates a tick
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            syncQ  <= '1;
            rxClkQ <= 1'b1;
        end else begin
            syncQ  <= {syncQ[SYNC_STAGES-2:0], rxd};
            rxClkQ <= rxClk;
        end
    end
    assign rxdS = syncQ[SYNC_STAGES-1];
    assign tick = rxClk & ~rxClkQ;
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receive framer with valid/ready byte output and error pulses.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 rxClk,
    input  logic                 osmSel,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 dataValid,
    input  logic                 dataReady,
    output logic                 rxBusy,
    output logic                 frameErr,
    output logic                 parityErr,
    output logic                 overrunErr
);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_t            state, stateNext;
    logic [3:0]           sampleCnt, sampleCntNext, lastCnt, midCnt;
    logic [2:0]           bitCnt, bitCntNext;
    logic [DATA_BITS-1:0] shiftReg, shiftNext;
    logic                 osmQ, osmNext, perrQ, perrNext;
    logic [4:0]           nSel;
    logic                 rxdS, tick, atLast, done, good;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) uSync (
        .clk   (clk),
        .rstN  (rstN),
        .rxd   (rxd),
        .rxClk (rxClk),
        .rxdS  (rxdS),
        .tick  (tick)
    );

    assign nSel    = osm_n(osmQ);
    assign lastCnt = 4'(nSel - 5'd1);
    assign midCnt  = nSel[4:1] - 4'd1;
    assign atLast  = sampleCnt == lastCnt;
    assign done    = tick && state == STOP && atLast;
    assign good    = done && rxdS && !perrQ;
    assign rxBusy  = state != IDLE;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            sampleCnt <= '0;
            bitCnt    <= '0;
            shiftReg  <= '0;
            osmQ      <= 1'b0;
            perrQ     <= 1'b0;
        end else begin
            state     <= stateNext;
            sampleCnt <= sampleCntNext;
            bitCnt    <= bitCntNext;
            shiftReg  <= shiftNext;
            osmQ      <= osmNext;
            perrQ     <= perrNext;
        end
    end

    always_comb begin
        stateNext     = state;
        sampleCntNext = sampleCnt;
        bitCntNext    = bitCnt;
        shiftNext     = shiftReg;
        osmNext       = osmQ;
        perrNext      = perrQ;
        if (tick) begin
            sampleCntNext = sampleCnt + 4'd1;
            case (state)
                IDLE: begin
                    sampleCntNext = '0;
                    if (!rxdS) begin
                        stateNext = START;
                        osmNext   = osmSel;
                        perrNext  = 1'b0;
                    end
                end
                START: if (sampleCnt == midCnt) begin
                    sampleCntNext = '0;
                    bitCntNext    = '0;
                    stateNext     = rxdS ? IDLE : DATA;
                end
                DATA: if (atLast) begin
                    sampleCntNext = '0;
                    shiftNext     = {rxdS, shiftReg[DATA_BITS-1:1]};
                    bitCntNext    = bitCnt + 3'd1;
                    if (bitCnt == LAST_BIT) stateNext = (PARITY_EN != 0) ? PARITY : STOP;
                end
                PARITY: if (atLast) begin
                    sampleCntNext = '0;
                    perrNext      = rxdS != ((^shiftReg) ^ (PARITY_ODD != 0));
                    stateNext     = STOP;
                end
                STOP: if (atLast) begin
                    sampleCntNext = '0;
                    stateNext     = IDLE;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // an accept in the same clk frees the holding register, so a good frame then loads instead of overrunning
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            dataOut    <= '0;
            dataValid  <= 1'b0;
            frameErr   <= 1'b0;
            parityErr  <= 1'b0;
            overrunErr <= 1'b0;
        end else begin
            frameErr   <= done && !rxdS;
            parityErr  <= done && rxdS && perrQ;
            overrunErr <= good && dataValid && !dataReady;
            if (good && (!dataValid || dataReady)) begin
                dataOut   <= shiftReg;
                dataValid <= 1'b1;
            end else if (dataReady) begin
                dataValid <= 1'b0;
            end
        end
    end
endmodule
